// File: rtl/micro_sequencer_mc_pkg.sv
// Shared definitions for the multi-channel micro-sequencer: opcodes, FSM states and
// instruction field positions.
package micro_sequencer_mc_pkg;

  localparam logic [7:0] OpNop  = 8'h00;
  localparam logic [7:0] OpHalt = 8'h01;
  localparam logic [7:0] OpSetp = 8'h02;
  localparam logic [7:0] OpWait = 8'h03;
  localparam logic [7:0] OpLdr  = 8'h04;
  localparam logic [7:0] OpDjnz = 8'h05;
  localparam logic [7:0] OpTrig = 8'h06;
  localparam logic [7:0] OpIrq  = 8'h07;

  localparam int unsigned OpcodeMsb    = 63;
  localparam int unsigned IdxMsb       = 55;
  localparam int unsigned ImmMsb       = 47;
  localparam int unsigned WaitCntWidth = 40;
  localparam int unsigned LoopWidth    = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StExec,
    StWaitRaster,
    StWaitTrig,
    StHalted,
    StError
  } state_e;

endpackage

// File: rtl/micro_sequencer_raster_div.sv
// Raster clock divider: free-running counter producing a one-cycle tick on the last count
// of each period.
module micro_sequencer_raster_div #(
  parameter int unsigned PERIOD = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = $clog2(PERIOD);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CntW'(PERIOD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/micro_sequencer_mc.sv
// Multi-channel micro-sequencer: fetches 64-bit instructions from BRAM and drives pulse words,
// with loop counters, raster waits, trigger waits and an error state.
module micro_sequencer_mc
  import micro_sequencer_mc_pkg::*;
#(
  parameter int unsigned BRAM_DATA_WIDTH        = 64,
  parameter int unsigned BRAM_ADDR_WIDTH        = 10,
  parameter int unsigned NUM_CHANNELS           = 4,
  parameter int unsigned PULSE_WIDTH            = 16,
  parameter int unsigned NUM_LOOP_REGS          = 4,
  parameter int unsigned MS_RASTER_CLOCK_PERIOD = 1250
) (
  input  logic                                S_AXI_ACLK,
  input  logic                                S_AXI_ARESET,
  input  logic                                start,
  input  logic                                abort,
  output logic [BRAM_ADDR_WIDTH-1:0]          bram_porta_addr,
  output logic                                bram_porta_en,
  input  logic [BRAM_DATA_WIDTH-1:0]          bram_porta_rddata,
  input  logic                                external_trigger,
  output logic [NUM_CHANNELS*PULSE_WIDTH-1:0] pulse,
  output logic [3:0]                          ps_interrupts,
  output logic                                raster_tick,
  output logic [BRAM_ADDR_WIDTH-1:0]          pc,
  output logic                                sequencer_active,
  output logic                                halted,
  output logic                                error
);

  state_e state_q, state_d;

  logic [BRAM_ADDR_WIDTH-1:0]                  pc_q, pc_d, pc_inc;
  logic [BRAM_DATA_WIDTH-1:0]                  ir_q, ir_d;
  logic [NUM_CHANNELS-1:0][PULSE_WIDTH-1:0]    pulse_q, pulse_d;
  logic [NUM_LOOP_REGS-1:0][LoopWidth-1:0]     loop_q, loop_d;
  logic [WaitCntWidth-1:0]                     wait_q, wait_d;
  logic [3:0]                                  irq_q, irq_d;
  logic                                        armed_q;
  logic [2:0]                                  trig_sync_q;
  logic                                        trig_rise_q;
  logic                                        div_clear, fault, ch_ok, reg_ok;
  logic [7:0]                                  opcode, idx;
  logic [ImmMsb:0]                             imm;
  logic [LoopWidth-1:0]                        loop_sel, loop_dec;
  logic                                        unused_imm_hi;

  assign opcode        = ir_q[OpcodeMsb -: 8];
  assign idx           = ir_q[IdxMsb -: 8];
  assign imm           = ir_q[ImmMsb:0];
  assign unused_imm_hi = ^imm[ImmMsb:WaitCntWidth];
  assign ch_ok         = 32'(idx) < NUM_CHANNELS;
  assign reg_ok        = 32'(idx) < NUM_LOOP_REGS;
  assign pc_inc        = pc_q + BRAM_ADDR_WIDTH'(1);

  assign sequencer_active = !(state_q inside {StIdle, StHalted, StError});
  assign halted           = state_q == StHalted;
  assign error            = state_q == StError;
  assign bram_porta_en    = state_q == StFetch;
  assign bram_porta_addr  = pc_q;
  assign pc               = pc_q;
  assign pulse            = pulse_q;
  assign ps_interrupts    = irq_q;

  micro_sequencer_raster_div #(
    .PERIOD (MS_RASTER_CLOCK_PERIOD)
  ) u_raster_div (
    .clk    (S_AXI_ACLK),
    .rst    (S_AXI_ARESET),
    .clear  (div_clear),
    .enable (sequencer_active),
    .tick   (raster_tick)
  );

  always_comb begin
    loop_sel = '0;
    for (int unsigned r = 0; r < NUM_LOOP_REGS; r++) begin
      if (32'(idx) == r) loop_sel = loop_q[r];
    end
  end
  assign loop_dec = loop_sel - LoopWidth'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pulse_d   = pulse_q;
    loop_d    = loop_q;
    wait_d    = wait_q;
    irq_d     = '0;
    div_clear = 1'b0;
    fault     = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StHalted, StError: begin
          // armed_q masks a start arriving with the first edge after reset release
          if (start && armed_q) begin
            state_d   = StFetch;
            pc_d      = '0;
            div_clear = 1'b1;
          end
        end
        StFetch: state_d = StLatch;
        StLatch: begin
          ir_d    = bram_porta_rddata;
          state_d = StExec;
        end
        StExec: begin
          state_d = StFetch;
          pc_d    = pc_inc;
          case (opcode)
            OpNop: ;
            OpHalt: begin
              state_d = StHalted;
              pc_d    = pc_q;
            end
            OpSetp: begin
              fault = !ch_ok;
              for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (32'(idx) == c) pulse_d[c] = imm[PULSE_WIDTH-1:0];
              end
            end
            OpWait: begin
              if (imm[WaitCntWidth-1:0] != '0) begin
                wait_d  = imm[WaitCntWidth-1:0];
                state_d = StWaitRaster;
                pc_d    = pc_q;
              end
            end
            OpLdr: begin
              fault = !reg_ok;
              for (int unsigned r = 0; r < NUM_LOOP_REGS; r++) begin
                if (32'(idx) == r) loop_d[r] = imm[LoopWidth-1:0];
              end
            end
            OpDjnz: begin
              fault = !reg_ok;
              for (int unsigned r = 0; r < NUM_LOOP_REGS; r++) begin
                if (32'(idx) == r) loop_d[r] = loop_dec;
              end
              if (loop_dec != '0) pc_d = imm[BRAM_ADDR_WIDTH-1:0];
            end
            OpTrig: begin
              state_d = StWaitTrig;
              pc_d    = pc_q;
            end
            OpIrq: irq_d = idx[3:0];
            default: fault = 1'b1;
          endcase
          // Bad index leaves pulse/loop state untouched since the writes above are gated
          if (fault) begin
            state_d = StError;
            pc_d    = pc_q;
            pulse_d = pulse_q;
            loop_d  = loop_q;
          end
        end
        StWaitRaster: begin
          if (raster_tick) begin
            wait_d = wait_q - WaitCntWidth'(1);
            if (wait_q == WaitCntWidth'(1)) begin
              state_d = StFetch;
              pc_d    = pc_inc;
            end
          end
        end
        StWaitTrig: begin
          if (trig_rise_q) begin
            state_d = StFetch;
            pc_d    = pc_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      pc_q        <= '0;
      ir_q        <= '0;
      pulse_q     <= '0;
      loop_q      <= '0;
      wait_q      <= '0;
      irq_q       <= '0;
      armed_q     <= 1'b0;
      trig_sync_q <= '0;
      trig_rise_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      pulse_q     <= pulse_d;
      loop_q      <= loop_d;
      wait_q      <= wait_d;
      irq_q       <= irq_d;
      armed_q     <= 1'b1;
      trig_sync_q <= {trig_sync_q[1:0], external_trigger};
      trig_rise_q <= trig_sync_q[1] & ~trig_sync_q[2];
    end
  end

endmodule
